// File: rtl/a_ffpipe_hs.sv
// Purpose : DEPTH-stage valid/ready register pipe with bubble collapsing,
//           synchronous flush (clr) and a registered occupancy count (occ).
// Latency : DEPTH cycles from input transfer to out_vld on an unstalled pipe.
// Backpr. : in_rdy drops only when every stage holds data and out_rdy=0;
//           out_rdy reaches in_rdy combinationally, outputs are registered.
// Ports   : clk, rst_n (async active-low), clr (sync flush),
//           in_vld/in_rdy/in_dat (upstream), out_vld/out_rdy/out_dat
//           (downstream), occ (number of valid stages).
module a_ffpipe_hs #(
  parameter int              SIZE    = 8,
  parameter int              DEPTH   = 4,
  parameter int              CNT_W   = 3,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [SIZE-1:0]  in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [SIZE-1:0]  out_dat,
  output logic [CNT_W-1:0] occ
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] load;
  logic [SIZE-1:0]  dat_q [DEPTH];
  logic [SIZE-1:0]  dat_d [DEPTH];
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             in_xfer;
  logic             out_xfer;

  // A stage can load when the output is being drained or when any stage
  // from itself to the output is empty (a bubble downstream will collapse).
  always_comb begin : p_load
    logic chain;
    chain = out_rdy;
    load  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain   = chain || !vld_q[i];
      load[i] = chain;
    end
  end

  // rst_n gates in_rdy so upstream never sees ready while held in reset.
  assign in_rdy   = load[0] && !clr && rst_n;
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = vld_q[DEPTH-1] && out_rdy;

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      dat_d[i] = dat_q[i];
    end

    if (clr) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_d[i] = RST_VAL;
      end
    end else begin
      if (load[0]) begin
        vld_d[0] = in_xfer;
        if (in_xfer) begin
          dat_d[0] = in_dat;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          vld_d[i] = vld_q[i-1];
          // Data only moves with a valid word, so a stage that takes a
          // bubble keeps its last value (out_dat holds when out_vld=0).
          if (vld_q[i-1]) begin
            dat_d[i] = dat_q[i-1];
          end
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    if (clr) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= RST_VAL;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];
  assign occ     = occ_q;

endmodule

// File: doc/a_ffpipe_hs.md
A_FFPIPE_HS -- requirements
Module: a_ffpipe_hs

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the data width in bits (SIZE >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages (DEPTH >= 1).
REQ-003 The block SHALL have parameter CNT_W, default 3, giving the occupancy counter width, which must be wide enough to hold the value DEPTH.
REQ-004 The block SHALL have parameter RST_VAL, default {SIZE{1'b0}}, giving the data register value after reset or clear.
REQ-005 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, input, 1 -- single clock; all state updates on its rising edge.
- rst_n, input, 1 -- asynchronous, active-low reset.
- clr, input, 1 -- synchronous flush, active high.
- in_vld, input, 1 -- upstream data valid.
- in_rdy, output, 1 -- block can accept in_dat this cycle.
- in_dat, input, SIZE -- upstream data.
- out_vld, output, 1 -- out_dat valid.
- out_rdy, input, 1 -- downstream accepts out_dat.
- out_dat, output, SIZE -- data from the last stage.
- occ, output, CNT_W -- number of valid stages.

Function
REQ-006 The block SHALL implement DEPTH stages, stage 0 at the input and stage DEPTH-1 at the output; each stage has one valid bit and one SIZE-bit data register.
REQ-007 A transfer SHALL occur at the input when in_vld && in_rdy, and at the output when out_vld && out_rdy; no other condition creates or removes an entry.
REQ-008 Stage DEPTH-1 SHALL be loadable when it is empty or out_rdy=1; stage i < DEPTH-1 SHALL be loadable when it is empty or stage i+1 is loadable (bubble collapsing).
REQ-009 When stage i is loadable, it SHALL capture the valid and data of stage i-1, or of in_vld/in_dat for stage 0.
REQ-010 A stage that is not loadable SHALL hold its valid bit and data unchanged.
REQ-011 in_rdy SHALL equal "stage 0 loadable" && !clr.
REQ-012 out_vld SHALL be the valid bit of stage DEPTH-1, and out_dat SHALL be its data register; out_dat is undefined for the consumer when out_vld=0, but SHALL hold its last value.
REQ-013 Latency SHALL be exactly DEPTH cycles from input transfer to out_vld on an unstalled pipe (out_rdy held 1).
REQ-014 Throughput SHALL be 1 word/cycle when out_rdy=1 continuously.
REQ-015 Data order SHALL be preserved, with no loss or duplication.
REQ-016 The pipe SHALL hold at most DEPTH words; when all stages are valid and out_rdy=0, in_rdy=0.
REQ-017 When a full pipe sees out_rdy=1 and in_vld=1 in the same cycle, both transfers SHALL occur and occ SHALL remain DEPTH.
REQ-018 out_rdy SHALL influence in_rdy combinationally; out_vld and out_dat SHALL come directly from registers.
REQ-019 occ SHALL equal the registered count of valid stages: +1 on an input transfer only, -1 on an output transfer only, unchanged on both or neither; it never exceeds DEPTH or wraps below 0.
REQ-020 When clr=1 at a clock edge, all valid bits SHALL become 0, all data registers RST_VAL, and occ 0.
REQ-021 When clr=1, an input presented in the same cycle SHALL be dropped and an output transfer in that cycle SHALL still count as taken.
REQ-022 clr SHALL take priority over all transfers.
REQ-023 With DEPTH=1, the block SHALL behave as a single-entry register slice that obeys REQ-008 to REQ-022.

Reset
REQ-024 While rst_n=0, asynchronously: all valid bits SHALL be 0, all data registers RST_VAL, and occ 0.
REQ-025 While rst_n=0: out_vld=0, out_dat=RST_VAL, and in_rdy=0 (forced low during reset).
REQ-026 Assertion of rst_n mid-stream SHALL discard all contents immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, in_rdy SHALL be 1 on the first clk edge with clr=0.

Verification (SIZE=8, DEPTH=4, RST_VAL=8'h00)
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset: rst_n=0, then release -> out_vld=0, out_dat=8'h00, occ=0, in_rdy=1.
- Streaming: out_rdy=1, push 8'h11, 8'h22, 8'h33 on consecutive cycles -> 8'h11 appears on out_vld 4 cycles after acceptance, then 8'h22 and 8'h33 back-to-back; occ peaks at 3.
- Fill: out_rdy=0, push 8'hA0..8'hA5 -> four accepted, in_rdy=0 from the 5th, occ=4; raise out_rdy -> outputs A0, A1, A2, A3 in order.
- Full pass-through: pipe full, out_rdy=1, in_vld=1 with 8'h5A -> one word out and 8'h5A in on the same edge; occ stays 4.
- Clear: occ=3, assert clr with in_vld=1 -> next cycle occ=0, out_vld=0, out_dat=8'h00, the input word is never output.
- Async reset: rst_n pulsed low between clock edges with occ=2 -> out_vld=0 and occ=0 before the next rising edge.
- Random: random in_vld and out_rdy for 10k cycles -> scoreboard shows in-order, lossless data and occ always equal to the count of stored words.
